// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if
//   Bundles the two requester ports and the BRAM bus of bram_port_arbiter.
//
//   Request/grant handshake (both requester ports):
//     A requester raises *_req (a level) together with a stable address,
//     and for the CPU, stable we/wdata. It keeps all of them stable until it
//     sees *_gnt high. *_gnt high means the access is on the BRAM bus in that
//     cycle, so the request is consumed. Keeping *_req high after the grant
//     asks for a new access. Dropping *_req before the grant cancels the
//     request without side effects. Read data returns one cycle after the
//     grant. It is qualified by a one-cycle *_rvalid pulse. A store returns
//     no rvalid.
//
//   Modports:
//     master : requesters plus the BRAM primitive (drive req/addr/wdata and
//              bram_rdata, observe grants, read data and the BRAM bus)
//     slave  : the arbiter
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // CPU load/store port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  // Display read-only port
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  // BRAM primitive bus
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output disp_req, disp_addr,
    output bram_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata,
    input  bram_addr, bram_we, bram_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  disp_req, disp_addr,
    input  bram_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output disp_gnt, disp_rvalid, disp_rdata,
    output bram_addr, bram_we, bram_wdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one single-port data BRAM between the CPU load/store path
//   (port A) and the read-only display scanner (port B). Grants last one
//   beat and are registered. The CPU has fixed priority. A wait counter
//   forces a display grant after MAX_WAIT denied cycles. BRAM read latency
//   is one cycle, and read data returns with a one-cycle valid strobe.
//
//   Optional build macro BRAM_ARB_RR_EN: when it is defined, contention is
//   resolved round-robin through a 1-bit last-winner register. The wait
//   counter guard stays in place.
//
// Ports:
//   clk           system clock, posedge
//   reset         synchronous, active-low
//   bus           bram_port_arbiter_if.slave (CPU port, display port,
//                 BRAM bus). The request/grant rules are documented in
//                 the interface file.
//   dbg_state     current bus owner: 0 IDLE, 1 ISSUE_CPU, 2 ISSUE_DISP
//   dbg_wait_cnt  display starvation counter
module bram_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  bram_port_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state,
  output logic [3:0]          dbg_wait_cnt
);

  // The state names the owner of the BRAM bus in the current cycle.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE_CPU  = 2'd1,
    ISSUE_DISP = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t            state;
  state_t            win;
  logic [3:0]        wait_cnt;
  logic              cpu_rvalid_q;
  logic              disp_rvalid_q;
  logic              bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_wdata_q;
  logic              cpu_el;
  logic              disp_el;
  logic              starved;
`ifdef BRAM_ARB_RR_EN
  logic              last_disp;  // 0 = CPU won last, 1 = display won last
`endif

  // A requester that owns the bus this cycle is not eligible at the next
  // edge. Each port therefore gets at most one access every two cycles,
  // which lets two continuous requesters alternate.
  always_comb begin
    cpu_el  = bus.cpu_req  && (state != ISSUE_CPU);
    disp_el = bus.disp_req && (state != ISSUE_DISP);
    starved = disp_el && (wait_cnt >= MAX_WAIT_C);
    win     = IDLE;
    if (starved) begin
      win = ISSUE_DISP;
`ifdef BRAM_ARB_RR_EN
    end else if (cpu_el && disp_el) begin
      win = last_disp ? ISSUE_CPU : ISSUE_DISP;
`endif
    end else if (cpu_el) begin
      win = ISSUE_CPU;
    end else if (disp_el) begin
      win = ISSUE_DISP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      cpu_rvalid_q  <= 1'b0;
      disp_rvalid_q <= 1'b0;
      bram_we_q     <= 1'b0;
      bram_addr_q   <= '0;
      bram_wdata_q  <= '0;
`ifdef BRAM_ARB_RR_EN
      last_disp     <= 1'b0;
`endif
    end else begin
      state <= win;

      // The read issued this cycle returns from the BRAM next cycle.
      cpu_rvalid_q  <= (state == ISSUE_CPU) && !bram_we_q;
      disp_rvalid_q <= (state == ISSUE_DISP);

      case (win)
        ISSUE_CPU: begin
          bram_addr_q  <= bus.cpu_addr;
          bram_we_q    <= bus.cpu_we;
          bram_wdata_q <= bus.cpu_wdata;
        end
        ISSUE_DISP: begin
          bram_addr_q <= bus.disp_addr;
          bram_we_q   <= 1'b0;
        end
        default: begin
          bram_we_q <= 1'b0;  // the address holds while the bus is idle
        end
      endcase

      // The counter advances only while the display is eligible and loses.
      // It holds while the display is not requesting.
      if (win == ISSUE_DISP) begin
        wait_cnt <= 4'd0;
      end else if (disp_el && (wait_cnt != 4'hF)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

`ifdef BRAM_ARB_RR_EN
      if (win == ISSUE_CPU) begin
        last_disp <= 1'b0;
      end else if (win == ISSUE_DISP) begin
        last_disp <= 1'b1;
      end
`endif
    end
  end

  assign bus.cpu_gnt     = (state == ISSUE_CPU);
  assign bus.disp_gnt    = (state == ISSUE_DISP);
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.cpu_rdata   = bus.bram_rdata;
  assign bus.disp_rdata  = bus.bram_rdata;
  assign bus.bram_addr   = bram_addr_q;
  assign bus.bram_we     = bram_we_q;
  assign bus.bram_wdata  = bram_wdata_q;
  assign dbg_state       = state;
  assign dbg_wait_cnt    = wait_cnt;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
//   Bench for bram_port_arbiter. It contains a behavioural BRAM, a
//   cycle-level reference of the arbitration rules with its own shadow
//   memory, and read-data scoreboards. The stimulus runs directed steps
//   and then randomized traffic.
module tb_bram_port_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;
  localparam int MEM_N    = 1024;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  logic [3:0] dbg_wait_cnt;

  always #5 clk = ~clk;

  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state),
    .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- BRAM model (read-first, 1-cycle latency) ----------------
  logic [DATA_W-1:0] mem [0:MEM_N-1];
  logic              pre_we;
  logic [9:0]        pre_addr;
  logic [DATA_W-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.bram_we) begin
      mem[bus.bram_addr[9:0]] <= bus.bram_wdata;
    end
    bus.bram_rdata <= mem[bus.bram_addr[9:0]];
  end

  // ---------------- reference model ----------------
  // m_bus: 0 = nobody, 1 = CPU, 2 = display on the BRAM bus this cycle
  int                m_bus;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  int                m_wait;
  bit                m_last_disp;
  bit                m_cpu_rv;
  bit                m_disp_rv;
  logic [DATA_W-1:0] gold [0:MEM_N-1];
  logic [DATA_W-1:0] exp_cpu_q[$];
  logic [DATA_W-1:0] exp_disp_q[$];
  logic [DATA_W-1:0] exp_v;

  int n_checks = 0;
  int n_errors = 0;
  int cpu_cnt;
  int disp_cnt;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock edge. The model resolves the edge from the inputs as
  // they stand, then the DUT outputs are compared 1 ns after the edge.
  task automatic step();
    int win;
    bit cel, del;
    if (!reset) begin
      m_bus = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_wait = 0; m_last_disp = 1'b0; m_cpu_rv = 1'b0; m_disp_rv = 1'b0;
      exp_cpu_q.delete();
      exp_disp_q.delete();
    end else begin
      m_cpu_rv  = (m_bus == 1) && !m_we;
      m_disp_rv = (m_bus == 2);
      if (m_cpu_rv)  exp_cpu_q.push_back(gold[m_addr[9:0]]);
      if (m_disp_rv) exp_disp_q.push_back(gold[m_addr[9:0]]);
      if (m_bus == 1 && m_we) gold[m_addr[9:0]] = m_wdata;
      cel = bus.cpu_req  && (m_bus != 1);
      del = bus.disp_req && (m_bus != 2);
      win = 0;
      if (del && m_wait >= MAX_WAIT) win = 2;
`ifdef BRAM_ARB_RR_EN
      else if (cel && del) win = m_last_disp ? 1 : 2;
`endif
      else if (cel) win = 1;
      else if (del) win = 2;
      if (win == 2) m_wait = 0;
      else if (del && m_wait < 15) m_wait++;
      if (win == 1) begin
        m_addr = bus.cpu_addr; m_we = bus.cpu_we; m_wdata = bus.cpu_wdata;
        m_last_disp = 1'b0;
      end else if (win == 2) begin
        m_addr = bus.disp_addr; m_we = 1'b0;
        m_last_disp = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      m_bus = win;
    end
    @(posedge clk);
    #1;
    chk("cpu_gnt",     32'(bus.cpu_gnt),     32'(m_bus == 1));
    chk("disp_gnt",    32'(bus.disp_gnt),    32'(m_bus == 2));
    chk("gnt_excl",    32'(bus.cpu_gnt & bus.disp_gnt), 32'd0);
    chk("bram_addr",   32'(bus.bram_addr),   32'(m_addr));
    chk("bram_we",     32'(bus.bram_we),     32'(m_we));
    chk("cpu_rvalid",  32'(bus.cpu_rvalid),  32'(m_cpu_rv));
    chk("disp_rvalid", 32'(bus.disp_rvalid), 32'(m_disp_rv));
    chk("state",       32'(dbg_state),       32'(m_bus));
    chk("wait_cnt",    32'(dbg_wait_cnt),    32'(m_wait));
    if (m_we) chk("bram_wdata", 32'(bus.bram_wdata), 32'(m_wdata));
    if (m_cpu_rv && exp_cpu_q.size() > 0) begin
      exp_v = exp_cpu_q.pop_front();
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_v));
    end
    if (m_disp_rv && exp_disp_q.size() > 0) begin
      exp_v = exp_disp_q.pop_front();
      chk("disp_rdata", 32'(bus.disp_rdata), 32'(exp_v));
    end
    if (bus.cpu_gnt)  cpu_cnt++;
    if (bus.disp_gnt) disp_cnt++;
  endtask

  // ---------------- driver helpers ----------------
  task automatic cpu_drive(input bit req, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic disp_drive(input bit req, input logic [15:0] addr);
    bus.disp_req = req; bus.disp_addr = addr;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
    disp_drive(1'b0, 16'h0);
    cpu_cnt = 0; disp_cnt = 0;

    // Preload memory and shadow memory through the backdoor while in reset.
    @(posedge clk); #1;
    for (int i = 0; i < MEM_N; i++) begin
      pre_addr = 10'(i);
      pre_data = (i == 16) ? 16'hBEEF : 16'($urandom);
      gold[i]  = pre_data;
      pre_we   = 1'b1;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    // Reset state.
    step();
    step();
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;

    // Single CPU load from 0x0010.
    cpu_drive(1'b1, 1'b0, 16'h0010, 16'h0);
    step();
    chk("t1_gnt",  32'(bus.cpu_gnt),   32'd1);
    chk("t1_addr", 32'(bus.bram_addr), 32'h0010);
    chk("t1_we",   32'(bus.bram_we),   32'd0);
    cpu_drive(1'b0, 1'b0, 16'h0010, 16'h0);
    step();
    chk("t1_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("t1_rdata",  32'(bus.cpu_rdata),  32'hBEEF);

    // Store then load 0x0020.
    cpu_drive(1'b1, 1'b1, 16'h0020, 16'h1234);
    step();
    chk("t2_we", 32'(bus.bram_we), 32'd1);
    cpu_drive(1'b1, 1'b0, 16'h0020, 16'h0);
    step();
    chk("t2_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    step();
    chk("t2_load_gnt", 32'(bus.cpu_gnt), 32'd1);
    cpu_drive(1'b0, 1'b0, 16'h0020, 16'h0);
    step();
    chk("t2_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("t2_rdata",  32'(bus.cpu_rdata),  32'h1234);

    // Both requesters held high: grants alternate.
    cpu_cnt = 0; disp_cnt = 0;
    cpu_drive(1'b1, 1'b0, 16'h0050, 16'h0);
    disp_drive(1'b1, 16'h0040);
    step();
`ifdef BRAM_ARB_RR_EN
    chk("t3_first_disp", 32'(bus.disp_gnt), 32'd1);
`else
    chk("t3_first_cpu", 32'(bus.cpu_gnt), 32'd1);
`endif
    for (int i = 0; i < 19; i++) step();
    chk("t3_cpu_cnt",  32'(cpu_cnt),  32'd10);
    chk("t3_disp_cnt", 32'(disp_cnt), 32'd10);
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
    disp_drive(1'b0, 16'h0);
    step();
    step();

    // Display only.
    cpu_cnt = 0; disp_cnt = 0;
    disp_drive(1'b1, 16'h0100);
    for (int i = 0; i < 12; i++) step();
    chk("t4_disp_cnt", 32'(disp_cnt), 32'd6);
    chk("t4_cpu_cnt",  32'(cpu_cnt),  32'd0);
    disp_drive(1'b0, 16'h0);
    step();
    step();

    // Reset during a granted CPU load.
    cpu_drive(1'b1, 1'b0, 16'h0030, 16'h0);
    step();
    chk("t5_gnt", 32'(bus.cpu_gnt), 32'd1);
    reset = 1'b0;
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
    step();
    chk("t5_gnt_clr",    32'(bus.cpu_gnt),    32'd0);
    chk("t5_rvalid_clr", 32'(bus.cpu_rvalid), 32'd0);
    chk("t5_state",      32'(dbg_state),      32'd0);
    chk("t5_wait",       32'(dbg_wait_cnt),   32'd0);
    reset = 1'b1;
    step();
    chk("t5_no_late_rvalid", 32'(bus.cpu_rvalid), 32'd0);

    // Randomized traffic. Requests stay stable until the grant is seen.
    // Occasionally a pending request is abandoned.
    for (int i = 0; i < 600; i++) begin
      if (!bus.cpu_req || m_bus == 1) begin
        cpu_drive($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, MEM_N - 1)), 16'($urandom));
      end else if ($urandom_range(0, 19) == 0) begin
        bus.cpu_req = 1'b0;
      end
      if (!bus.disp_req || m_bus == 2) begin
        disp_drive($urandom_range(0, 99) < 70, 16'($urandom_range(0, MEM_N - 1)));
      end else if ($urandom_range(0, 19) == 0) begin
        bus.disp_req = 1'b0;
      end
      step();
    end
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
    disp_drive(1'b0, 16'h0);
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port data BRAM between two requesters: the CPU load/store path (port A) and the pong display scanner (port B, read-only).
- Sits between the CPU datapath/FSM, the display pixel fetch logic and the BRAM primitive.
- Registered single-beat grants, fixed CPU priority, starvation guard for the display.
- BRAM read latency is 1 cycle; the arbiter returns data with a valid strobe.

Parameters:
ADDR_W, 16, BRAM address width
DATA_W, 16, BRAM data width
MAX_WAIT, 4, cycles disp_req may be denied before a forced display grant (range 1-15)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
cpu_req  in  1  CPU access request (level)
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_gnt  out  1  CPU access on BRAM bus this cycle
cpu_rvalid  out  1  cpu_rdata valid (1-cycle pulse)
cpu_rdata  out  DATA_W  load data
disp_req  in  1  display read request (level)
disp_addr  in  ADDR_W  display address
disp_gnt  out  1  display access on BRAM bus this cycle
disp_rvalid  out  1  disp_rdata valid (1-cycle pulse)
disp_rdata  out  DATA_W  display read data
bram_addr  out  ADDR_W  BRAM address (registered)
bram_we  out  1  BRAM write enable (registered)
bram_wdata  out  DATA_W  BRAM write data (registered)
bram_rdata  in  DATA_W  BRAM read data, valid 1 cycle after address

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; cpu_gnt, disp_gnt, cpu_rvalid, disp_rvalid, bram_we = 0; bram_addr, bram_wdata = 0; wait_cnt=0. In-flight read is dropped (no rvalid after reset).
- States = what is on the BRAM bus this cycle: IDLE, ISSUE_CPU, ISSUE_DISP. cpu_gnt = (state==ISSUE_CPU); disp_gnt = (state==ISSUE_DISP).
- Eligibility at each posedge: cpu_el = cpu_req && !cpu_gnt; disp_el = disp_req && !disp_gnt. A granted requester cannot win the following cycle, so each requester gets at most 1 access per 2 cycles.
- Winner: if disp_el && wait_cnt>=MAX_WAIT -> DISP; else if cpu_el -> CPU; else if disp_el -> DISP; else IDLE.
- On a win, register the winner's address into bram_addr. For a CPU win, also register cpu_we into bram_we and cpu_wdata into bram_wdata. For a DISP win, bram_we=0. For IDLE, bram_we=0 and bram_addr holds its value.
- Latency: req sampled at edge N -> gnt and bram bus in cycle N+1 -> rvalid and rdata in cycle N+2.
- Requesters hold req, addr, we and wdata stable until gnt is seen. Keeping req high after gnt requests a new access.
- cpu_rvalid <= cpu_gnt && !bram_we; disp_rvalid <= disp_gnt. cpu_rdata and disp_rdata are driven directly from bram_rdata and are only meaningful while the matching rvalid is high.
- Stores produce no rvalid.
- wait_cnt: cleared when the display wins. Otherwise incremented (saturating at 15) at each edge where disp_el is true and the display loses. Held when disp_req is low.
- Simultaneous cpu_el and disp_el with wait_cnt<MAX_WAIT: CPU wins.
- Requests dropped before grant: no access, no error.

Optional Feature:
BRAM_ARB_RR_EN:
- Defined: fixed priority is replaced by round-robin. A 1-bit last-winner register (reset 0 = CPU) gives priority to the non-last winner on contention. The wait_cnt forced grant is retained but is redundant.
- Undefined: fixed CPU priority plus starvation guard, exactly as above.

Test Plan:
- Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x0010, BRAM holds 0xBEEF -> cpu_gnt high in cycle 1 with bram_addr=0x0010 and bram_we=0; cpu_rvalid=1, cpu_rdata=0xBEEF in cycle 2.
- CPU store addr=0x0020, wdata=0x1234, then load 0x0020 -> bram_we=1 for one cycle with no rvalid; the load returns 0x1234.
- cpu_req and disp_req held high continuously, MAX_WAIT=4 -> grants alternate CPU/DISP; disp_rvalid every 2 cycles; no grant pair is ever both high.
- Display only, disp_req held, addr 0x0100 -> disp_gnt pulses every other cycle; disp_rdata matches BRAM; cpu_gnt stays 0.
- Assert reset during the cycle a CPU load is granted -> cpu_gnt and cpu_rvalid are 0 next cycle; state=IDLE; wait_cnt=0.
- With BRAM_ARB_RR_EN defined, simultaneous first requests -> DISP wins the first contention (last=CPU after reset), then grants alternate.
